// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: opcodes, FSM states, bus widths.
// Pure declarations plus one opcode decode helper; no logic, no latency.
// No flow control here; consumers decide how to stall.
package mem_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // last is the index of the final byte (n-1)
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [1:0] last;
  } op_info_t;

  // Undefined codes decode to neither load nor store, i.e. behave as NONE
  function automatic op_info_t decode_op(input logic [3:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_LB, OP_LBU: begin info.is_load  = 1'b1; info.last = 2'd0; end
      OP_LH, OP_LHU: begin info.is_load  = 1'b1; info.last = 2'd1; end
      OP_LW:         begin info.is_load  = 1'b1; info.last = 2'd3; end
      OP_SB:         begin info.is_store = 1'b1; info.last = 2'd0; end
      OP_SH:         begin info.is_store = 1'b1; info.last = 2'd1; end
      OP_SW:         begin info.is_store = 1'b1; info.last = 2'd3; end
      default:       info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory bus between the memory stage and the RAM/arbiter.
// Read data arrives one cycle after its address.
// Grant-based: requester holds mem_req until mem_gnt is seen.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [BYTE_W-1:0] ram_dout;
  logic [BYTE_W-1:0] ram_din;

  modport master (output mem_req, ram_addr, ram_wr, ram_dout,
                  input  mem_gnt, ram_din);
  modport slave  (input  mem_req, ram_addr, ram_wr, ram_dout,
                  output mem_gnt, ram_din);

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load extension: sign/zero-extends the little-endian load buffer per opcode.
// Purely combinational, zero latency.
// No flow control.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]        memop,
  input  logic [DATA_W-1:0] buffer,
  output logic [DATA_W-1:0] value
);

  // Pick width and signedness from the opcode; LW passes the buffer through
  always_comb begin
    value = buffer;
    case (memop)
      OP_LB:   value = {{24{buffer[7]}},  buffer[7:0]};
      OP_LBU:  value = {24'd0,            buffer[7:0]};
      OP_LH:   value = {{16{buffer[15]}}, buffer[15:0]};
      OP_LHU:  value = {16'd0,            buffer[15:0]};
      default: value = buffer;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: byte-serial loads/stores over an arbitrated byte bus.
// Non-memory ops: 1 cycle. Memory ops: grant + n access cycles (+1 capture for loads).
// Raises stall_req for every cycle of a memory op except the completing one.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_memop,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_sdata,
  input  logic [REG_W-1:0]  in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  mem_stage_if.master       bus,
  output logic              stall_req,
  output logic [REG_W-1:0]  wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] ext_value;
  logic [1:0]        cap_idx;
  logic              cap_en;
  logic              wb_load;
  logic              wb_ext;
  op_info_t          op;

  assign op = decode_op(in_memop);

  // Merge the returning read byte into the buffer; the CAPTURE byte is fed
  // straight into extension so writeback does not need an extra cycle
  always_comb begin
    buf_d   = buf_q;
    cap_idx = (state_q == ST_CAPTURE) ? op.last : (cnt_q - 2'd1);
    cap_en  = op.is_load &&
              (((state_q == ST_ACCESS) && (cnt_q != 2'd0)) || (state_q == ST_CAPTURE));
    if (cap_en) begin
      buf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end
  end

  load_ext u_load_ext (
    .memop  (in_memop),
    .buffer (buf_d),
    .value  (ext_value)
  );

  // Next-state and bus/stall outputs; everything is forced quiet during reset
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus.mem_req  = 1'b0;
    bus.ram_wr   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_dout = '0;
    stall_req    = 1'b0;
    wb_load      = 1'b0;
    wb_ext       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op.is_load || op.is_store) begin
          bus.mem_req = 1'b1;
          stall_req   = 1'b1;
          if (bus.mem_gnt) begin
            state_d = ST_ACCESS;
            cnt_d   = 2'd0;
          end
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_ACCESS: begin
        bus.mem_req  = 1'b1;
        bus.ram_addr = in_addr + {30'd0, cnt_q};
        bus.ram_wr   = op.is_store;
        bus.ram_dout = op.is_store ? in_sdata[{cnt_q, 3'b000} +: 8] : 8'd0;
        stall_req    = 1'b1;
        if (cnt_q != op.last) begin
          cnt_d = cnt_q + 2'd1;
        end else if (op.is_store) begin
          state_d   = ST_IDLE;
          stall_req = 1'b0;
          wb_load   = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        wb_load = 1'b1;
        wb_ext  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst) begin
      bus.mem_req  = 1'b0;
      bus.ram_wr   = 1'b0;
      bus.ram_addr = '0;
      bus.ram_dout = '0;
      stall_req    = 1'b0;
    end
  end

  // FSM state, byte counter and load buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Writeback registers load on the completing edge of every op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
    end else if (wb_load) begin
      wb_wd    <= in_wd;
      wb_wreg  <= in_wreg;
      wb_wdata <= wb_ext ? ext_value : in_wdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-addressed RAM model on the bus.
// RAM read data returns one cycle after the address, as the bus defines.
// Grant is driven by the scenario tasks to exercise arbitration waits.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_memop;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_wdata;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] ram [bit [31:0]];

  mem_stage_if bus();

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_memop  (in_memop),
    .in_addr   (in_addr),
    .in_sdata  (in_sdata),
    .in_wd     (in_wd),
    .in_wreg   (in_wreg),
    .in_wdata  (in_wdata),
    .bus       (bus),
    .stall_req (stall_req),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata)
  );

  always #5 clk = ~clk;

  // RAM model: writes on the strobe, read byte lands one cycle later
  always @(posedge clk) begin
    bus.ram_din <= ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : 8'h00;
    if (bus.ram_wr === 1'b1) ram[bus.ram_addr] = bus.ram_dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op with immediate grant, run to completion, return wb_wdata
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] wd,
                        output logic [31:0] res, output int cycles);
    in_memop = op; in_addr = addr; in_sdata = 32'h0; in_wdata = wdata;
    in_wd = wd; in_wreg = 1'b1; bus.mem_gnt = 1'b1;
    #1;
    cycles = 0;
    while (stall_req !== 1'b0 && cycles < 20) begin
      step();
      cycles++;
    end
    vec_cnt++;
    if (cycles >= 20) begin
      err_cnt++;
      $display("FAIL run_op_timeout: stall_req=%b still high after %0d cycles, required low", stall_req, cycles);
    end
    step();
    res = wb_wdata;
    in_memop = OP_NONE;
    bus.mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_memop = OP_LW; in_addr = 32'h100; in_sdata = 32'hFFFF_FFFF;
    in_wd = 5'd3; in_wreg = 1'b1; in_wdata = 32'h1;
    bus.mem_gnt = 1'b1;
    step(); step();
    vec_cnt++; if (bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    vec_cnt++; if (bus.ram_wr !== 1'b0) begin err_cnt++; $display("FAIL reset_ram_wr: got %b expected 0", bus.ram_wr); end
    vec_cnt++; if (bus.ram_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_ram_addr: got %h expected 0", bus.ram_addr); end
    vec_cnt++; if (bus.ram_dout !== 8'h0) begin err_cnt++; $display("FAIL reset_ram_dout: got %h expected 0", bus.ram_dout); end
    vec_cnt++; if ({wb_wd, wb_wreg, wb_wdata} !== 38'h0) begin err_cnt++; $display("FAIL reset_wb: got %h/%b/%h expected 0", wb_wd, wb_wreg, wb_wdata); end
    in_memop = OP_NONE; bus.mem_gnt = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_nonmem();
    in_memop = OP_NONE; in_wdata = 32'h1234_5678; in_wd = 5'd5; in_wreg = 1'b1;
    #1;
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL nonmem_stall_pre: got %b expected 0", stall_req); end
    vec_cnt++; if (bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL nonmem_mem_req: got %b expected 0", bus.mem_req); end
    step();
    vec_cnt++; if (wb_wdata !== 32'h1234_5678) begin err_cnt++; $display("FAIL nonmem_wdata: got %h expected 12345678", wb_wdata); end
    vec_cnt++; if (wb_wd !== 5'd5) begin err_cnt++; $display("FAIL nonmem_wd: got %0d expected 5", wb_wd); end
    vec_cnt++; if (wb_wreg !== 1'b1) begin err_cnt++; $display("FAIL nonmem_wreg: got %b expected 1", wb_wreg); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL nonmem_stall_post: got %b expected 0", stall_req); end
  endtask

  task automatic test_lw();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h100, 32'h101, 32'h102, 32'h103};
    in_memop = OP_LW; in_addr = 32'h100; in_wd = 5'd7; in_wreg = 1'b1;
    in_wdata = 32'hDEAD_0000; bus.mem_gnt = 1'b1;
    #1;
    vec_cnt++; if ({bus.mem_req, stall_req} !== 2'b11) begin err_cnt++; $display("FAIL lw_req_c0: got req/stall %b%b expected 11", bus.mem_req, stall_req); end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.mem_gnt = 1'b0;
      vec_cnt++; if (bus.ram_addr !== exp_addr[i]) begin err_cnt++; $display("FAIL lw_addr_c%0d: got %h expected %h", i + 1, bus.ram_addr, exp_addr[i]); end
      vec_cnt++; if ({bus.ram_wr, stall_req} !== 2'b01) begin err_cnt++; $display("FAIL lw_wr_stall_c%0d: got wr/stall %b%b expected 01", i + 1, bus.ram_wr, stall_req); end
    end
    step();
    vec_cnt++; if ({bus.mem_req, stall_req} !== 2'b00) begin err_cnt++; $display("FAIL lw_capture_c5: got req/stall %b%b expected 00", bus.mem_req, stall_req); end
    step();
    vec_cnt++; if (wb_wdata !== 32'h1234_5678) begin err_cnt++; $display("FAIL lw_wdata: got %h expected 12345678", wb_wdata); end
    vec_cnt++; if (wb_wd !== 5'd7) begin err_cnt++; $display("FAIL lw_wd: got %0d expected 7", wb_wd); end
    in_memop = OP_NONE;
  endtask

  task automatic test_load_ext();
    logic [31:0] res;
    int cyc;
    run_op(OP_LB, 32'h200, 32'h0, 5'd1, res, cyc);
    vec_cnt++; if (res !== 32'hFFFF_FF80) begin err_cnt++; $display("FAIL lb_sign: got %h expected ffffff80", res); end
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL lb_cycles: got %0d expected 2", cyc); end
    run_op(OP_LBU, 32'h200, 32'h0, 5'd1, res, cyc);
    vec_cnt++; if (res !== 32'h0000_0080) begin err_cnt++; $display("FAIL lbu_zero: got %h expected 00000080", res); end
    run_op(OP_LB, 32'h201, 32'h0, 5'd1, res, cyc);
    vec_cnt++; if (res !== 32'h0000_007F) begin err_cnt++; $display("FAIL lb_pos: got %h expected 0000007f", res); end
    run_op(OP_LH, 32'h300, 32'h0, 5'd2, res, cyc);
    vec_cnt++; if (res !== 32'hFFFF_8000) begin err_cnt++; $display("FAIL lh_sign: got %h expected ffff8000", res); end
    vec_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL lh_cycles: got %0d expected 3", cyc); end
    run_op(OP_LHU, 32'h300, 32'h0, 5'd2, res, cyc);
    vec_cnt++; if (res !== 32'h0000_8000) begin err_cnt++; $display("FAIL lhu_zero: got %h expected 00008000", res); end
    run_op(OP_LW, 32'h101, 32'h0, 5'd2, res, cyc);
    vec_cnt++; if (res !== 32'h7F12_3456) begin err_cnt++; $display("FAIL lw_unaligned: got %h expected 7f123456", res); end
  endtask

  task automatic test_sh_wrap();
    in_memop = OP_SH; in_addr = 32'hFFFF_FFFF; in_sdata = 32'hAABB_CCDD;
    in_wdata = 32'h0000_BEEF; in_wd = 5'd3; in_wreg = 1'b1; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    vec_cnt++; if ({bus.ram_addr, bus.ram_wr, bus.ram_dout, stall_req} !== {32'hFFFF_FFFF, 1'b1, 8'hDD, 1'b1}) begin
      err_cnt++; $display("FAIL sh_cyc1: got addr %h wr %b dout %h stall %b expected ffffffff 1 dd 1", bus.ram_addr, bus.ram_wr, bus.ram_dout, stall_req); end
    step();
    vec_cnt++; if ({bus.ram_addr, bus.ram_wr, bus.ram_dout, stall_req} !== {32'h0, 1'b1, 8'hCC, 1'b0}) begin
      err_cnt++; $display("FAIL sh_cyc2_wrap: got addr %h wr %b dout %h stall %b expected 00000000 1 cc 0", bus.ram_addr, bus.ram_wr, bus.ram_dout, stall_req); end
    step();
    in_memop = OP_NONE;
    vec_cnt++; if (wb_wdata !== 32'h0000_BEEF) begin err_cnt++; $display("FAIL sh_wb_wdata: got %h expected 0000beef", wb_wdata); end
    vec_cnt++; if (ram[32'h0] !== 8'hCC) begin err_cnt++; $display("FAIL sh_ram0: got %h expected cc", ram[32'h0]); end
  endtask

  task automatic test_sw_wait();
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    in_memop = OP_SW; in_addr = 32'h400; in_sdata = 32'h1122_3344;
    in_wdata = 32'h0; in_wd = 5'd4; in_wreg = 1'b0; bus.mem_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if ({bus.mem_req, stall_req, bus.ram_wr} !== 3'b110) begin
        err_cnt++; $display("FAIL sw_wait%0d: got req/stall/wr %b%b%b expected 110", i, bus.mem_req, stall_req, bus.ram_wr); end
      step();
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== {1'b1, 32'h400 + 32'(i), exp_b[i]}) begin
        err_cnt++; $display("FAIL sw_write%0d: got wr %b addr %h dout %h expected 1 %h %h", i, bus.ram_wr, bus.ram_addr, bus.ram_dout, 32'h400 + 32'(i), exp_b[i]); end
      vec_cnt++; if (stall_req !== (i == 3 ? 1'b0 : 1'b1)) begin
        err_cnt++; $display("FAIL sw_stall%0d: got %b expected %b", i, stall_req, (i == 3 ? 1'b0 : 1'b1)); end
      step();
    end
    in_memop = OP_NONE;
    vec_cnt++; if (ram[32'h403] !== 8'h11) begin err_cnt++; $display("FAIL sw_ram403: got %h expected 11", ram[32'h403]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int cyc;
    in_memop = OP_LW; in_addr = 32'h100; in_wd = 5'd6; in_wreg = 1'b1;
    in_wdata = 32'h0; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    step(); step();
    vec_cnt++; if (bus.ram_addr !== 32'h102) begin err_cnt++; $display("FAIL rstmid_at_cnt2: got %h expected 00000102", bus.ram_addr); end
    rst = 1'b0;
    #1;
    vec_cnt++; if ({bus.mem_req, bus.ram_wr, bus.ram_addr, bus.ram_dout, stall_req} !== 43'h0) begin
      err_cnt++; $display("FAIL rstmid_bus: got req %b wr %b addr %h dout %h stall %b expected all 0", bus.mem_req, bus.ram_wr, bus.ram_addr, bus.ram_dout, stall_req); end
    vec_cnt++; if ({wb_wd, wb_wreg, wb_wdata} !== 38'h0) begin err_cnt++; $display("FAIL rstmid_wb: got %h/%b/%h expected 0", wb_wd, wb_wreg, wb_wdata); end
    step();
    vec_cnt++; if (bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL rstmid_held: got mem_req %b expected 0", bus.mem_req); end
    rst = 1'b1;
    run_op(OP_LW, 32'h100, 32'h0, 5'd6, res, cyc);
    vec_cnt++; if (res !== 32'h1234_5678) begin err_cnt++; $display("FAIL rstmid_rerun: got %h expected 12345678", res); end
    vec_cnt++; if (cyc !== 5) begin err_cnt++; $display("FAIL rstmid_cycles: got %0d expected 5", cyc); end
  endtask

  task automatic test_undef();
    in_memop = 4'hF; in_wdata = 32'hA5A5_A5A5; in_wd = 5'd9; in_wreg = 1'b1;
    bus.mem_gnt = 1'b1;
    #1;
    vec_cnt++; if ({bus.mem_req, stall_req} !== 2'b00) begin err_cnt++; $display("FAIL undef_req: got req/stall %b%b expected 00", bus.mem_req, stall_req); end
    step();
    vec_cnt++; if ({wb_wd, wb_wdata} !== {5'd9, 32'hA5A5_A5A5}) begin err_cnt++; $display("FAIL undef_wb: got %0d/%h expected 9/a5a5a5a5", wb_wd, wb_wdata); end
    in_memop = OP_NONE; bus.mem_gnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56;
    ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h104] = 8'h7F;
    ram[32'h200] = 8'h80; ram[32'h201] = 8'h7F;
    ram[32'h300] = 8'h00; ram[32'h301] = 8'h80;
    bus.mem_gnt = 1'b0;
    test_reset();
    test_nonmem();
    test_lw();
    test_load_ext();
    test_sh_wrap();
    test_sw_wait();
    test_reset_mid();
    test_undef();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
